arithmetic_logic_unit: RTL and testbench



---
 rtl/arithmetic_logic_unit_pkg.sv | 39 +++
 rtl/arithmetic_logic_unit_if.sv | 14 +
 rtl/alu_flag_reg.sv | 23 ++
 rtl/arithmetic_logic_unit.sv | 149 ++++++++++++++
 tb/tb_arithmetic_logic_unit.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/arithmetic_logic_unit_pkg.sv
// Shared definitions for the datapath ALU: operation codes, width-select bit,
// flag bit positions and width helpers.
package arithmetic_logic_unit_pkg;

    typedef enum logic [3:0] {
        OP_PASS_A = 4'h0,
        OP_PASS_B = 4'h1,
        OP_NOT_A  = 4'h2,
        OP_NOT_B  = 4'h3,
        OP_ADD    = 4'h4,
        OP_ADC    = 4'h5,
        OP_SUB    = 4'h6,
        OP_AND    = 4'h7,
        OP_OR     = 4'h8,
        OP_XOR    = 4'h9,
        OP_NAND   = 4'hA,
        OP_LSL    = 4'hB,
        OP_LSR    = 4'hC,
        OP_ASR    = 4'hD,
        OP_CSL    = 4'hE,
        OP_CSR    = 4'hF
    } aluOp_e;

    localparam int WIDTH_SEL_BIT = 4;
    localparam int FLAG_Z        = 3;
    localparam int FLAG_C        = 2;
    localparam int FLAG_N        = 1;
    localparam int FLAG_O        = 0;

    // Sign bit of a value in the active width (bit 15 or bit 7).
    function automatic logic msbOf(input logic [15:0] value, input logic is16);
        return is16 ? value[15] : value[7];
    endfunction

    function automatic logic [15:0] widthMask(input logic is16);
        return is16 ? 16'hFFFF : 16'h00FF;
    endfunction

endpackage

// File: rtl/arithmetic_logic_unit_if.sv
// Operand/result bus of the datapath ALU; the ALU takes the slave side.
interface arithmetic_logic_unit_if;
    logic [15:0] A;
    logic [15:0] B;
    logic [4:0]  FunSel;
    logic        WF;
    logic [15:0] ALUOut;
    logic [3:0]  FlagsOut;

    modport master (output A, output B, output FunSel, output WF,
                    input  ALUOut, input FlagsOut);
    modport slave  (input  A, input  B, input  FunSel, input  WF,
                    output ALUOut, output FlagsOut);
endinterface

// File: rtl/alu_flag_reg.sv
// {Z,C,N,O} flags register: async active-low clear, WF-gated write where only
// the bits selected by updMask take the new value.
module alu_flag_reg (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       WF,
    input  logic [3:0] flagsNext,
    input  logic [3:0] updMask,
    output logic [3:0] flags_r
);

    // Flag storage with per-bit update mask
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            flags_r <= 4'b0000;
        end else if (WF) begin
            flags_r <= (flags_r & ~updMask) | (flagsNext & updMask);
        end else begin
            flags_r <= flags_r;
        end
    end

endmodule

// File: rtl/arithmetic_logic_unit.sv
// Combinational 8/16-bit ALU with registered {Z,C,N,O} flags.
// Define ALU_ROTATE_EN to enable rotate-through-carry on codes E/F.
module arithmetic_logic_unit
    import arithmetic_logic_unit_pkg::*;
(
    input  logic                   Clock,
    input  logic                   Reset,
    arithmetic_logic_unit_if.slave bus
);

    aluOp_e      opCode_s;
    logic        is16_s;
    logic        carryIn_s;
    logic [15:0] opA_s;
    logic [15:0] opB_s;
    logic [15:0] addB_s;
    logic        addCin_s;
    logic [16:0] sum_s;
    logic        carryOut_s;
    logic        ovf_s;
    logic [15:0] rawResult_s;
    logic [15:0] result_s;
    logic        shiftOut_s;
    logic        resMsb_s;
    logic [3:0]  flagsNext_s;
    logic [3:0]  updMask_s;
    logic [3:0]  flags_s;

    assign opCode_s  = aluOp_e'(bus.FunSel[3:0]);
    assign is16_s    = bus.FunSel[WIDTH_SEL_BIT];
    assign carryIn_s = flags_s[FLAG_C];
    assign opA_s     = bus.A & widthMask(is16_s);
    assign opB_s     = bus.B & widthMask(is16_s);

    // Shared adder: operand select for add, add-with-carry and subtract
    always_comb begin
        addB_s   = opB_s;
        addCin_s = 1'b0;
        case (opCode_s)
            OP_ADC: begin
                addB_s   = opB_s;
                addCin_s = carryIn_s;
            end
            OP_SUB: begin
                addB_s   = ~bus.B & widthMask(is16_s);
                addCin_s = 1'b1;
            end
            default: begin
                addB_s   = opB_s;
                addCin_s = 1'b0;
            end
        endcase
        sum_s      = {1'b0, opA_s} + {1'b0, addB_s} + {16'h0000, addCin_s};
        carryOut_s = is16_s ? sum_s[16] : sum_s[8];
        ovf_s      = (msbOf(opA_s, is16_s) == msbOf(addB_s, is16_s)) &&
                     (msbOf(sum_s[15:0], is16_s) != msbOf(opA_s, is16_s));
    end

    // Result multiplexer; upper byte is cleared by the width mask in 8-bit mode
    always_comb begin
        rawResult_s = 16'h0000;
        shiftOut_s  = 1'b0;
        case (opCode_s)
            OP_PASS_A: rawResult_s = opA_s;
            OP_PASS_B: rawResult_s = opB_s;
            OP_NOT_A:  rawResult_s = ~opA_s;
            OP_NOT_B:  rawResult_s = ~opB_s;
            OP_ADD, OP_ADC, OP_SUB: rawResult_s = sum_s[15:0];
            OP_AND:    rawResult_s = opA_s & opB_s;
            OP_OR:     rawResult_s = opA_s | opB_s;
            OP_XOR:    rawResult_s = opA_s ^ opB_s;
            OP_NAND:   rawResult_s = ~(opA_s & opB_s);
            OP_LSL: begin
                rawResult_s = {opA_s[14:0], 1'b0};
                shiftOut_s  = msbOf(opA_s, is16_s);
            end
            OP_LSR: begin
                rawResult_s = {1'b0, opA_s[15:1]};
                shiftOut_s  = opA_s[0];
            end
            OP_ASR: begin
                rawResult_s = is16_s ? {opA_s[15], opA_s[15:1]}
                                     : {8'h00, opA_s[7], opA_s[7:1]};
                shiftOut_s  = opA_s[0];
            end
`ifdef ALU_ROTATE_EN
            OP_CSL: begin
                rawResult_s = {opA_s[14:0], carryIn_s};
                shiftOut_s  = msbOf(opA_s, is16_s);
            end
            OP_CSR: begin
                rawResult_s = is16_s ? {carryIn_s, opA_s[15:1]}
                                     : {8'h00, carryIn_s, opA_s[7:1]};
                shiftOut_s  = opA_s[0];
            end
`else
            OP_CSL, OP_CSR: begin
                rawResult_s = opA_s;
                shiftOut_s  = 1'b0;
            end
`endif
            default: begin
                rawResult_s = 16'h0000;
                shiftOut_s  = 1'b0;
            end
        endcase
        result_s = rawResult_s & widthMask(is16_s);
        resMsb_s = msbOf(result_s, is16_s);
    end

    // Candidate flag values and which of them each operation may change
    always_comb begin
        flagsNext_s         = 4'b0000;
        updMask_s           = 4'b0000;
        flagsNext_s[FLAG_Z] = (result_s == 16'h0000);
        flagsNext_s[FLAG_N] = resMsb_s;
        flagsNext_s[FLAG_C] = shiftOut_s;
        flagsNext_s[FLAG_O] = ovf_s;
        case (opCode_s)
            OP_ADD, OP_ADC, OP_SUB: begin
                // N reports the true sign even when the sum overflowed
                flagsNext_s[FLAG_N] = resMsb_s ^ ovf_s;
                flagsNext_s[FLAG_C] = carryOut_s;
                updMask_s           = 4'b1111;
            end
            OP_LSL, OP_LSR: updMask_s = 4'b1110;
            OP_ASR:         updMask_s = 4'b1100;
`ifdef ALU_ROTATE_EN
            OP_CSL, OP_CSR: updMask_s = 4'b1110;
`else
            OP_CSL, OP_CSR: updMask_s = 4'b0000;
`endif
            default:        updMask_s = 4'b1010;
        endcase
    end

    alu_flag_reg u_flagReg (
        .Clock     (Clock),
        .Reset     (Reset),
        .WF        (bus.WF),
        .flagsNext (flagsNext_s),
        .updMask   (updMask_s),
        .flags_r   (flags_s)
    );

    assign bus.ALUOut   = result_s;
    assign bus.FlagsOut = flags_s;

endmodule

// File: tb/tb_arithmetic_logic_unit.sv
// Directed-vector bench for arithmetic_logic_unit; flags are written {Z,C,N,O}.
module tb_arithmetic_logic_unit;

    logic Clock;
    logic Reset;
    int   totalChecks;
    int   passChecks;

    arithmetic_logic_unit_if bus ();

    arithmetic_logic_unit dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
        totalChecks++;
        if (got === exp) begin
            passChecks++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyOp(input logic [4:0] fs, input logic [15:0] a,
                           input logic [15:0] b, input logic wf);
        bus.FunSel = fs;
        bus.A      = a;
        bus.B      = b;
        bus.WF     = wf;
        #1;
    endtask

    task automatic clockEdge();
        @(posedge Clock);
        #1;
    endtask

    task automatic checkFlags(input string tag, input logic [3:0] exp);
        checkVal(tag, {12'h000, bus.FlagsOut}, {12'h000, exp});
    endtask

    // Reach an arbitrary flag state: ADD sets O, pass sets N, ASR sets Z and C
    task automatic presetFlags(input logic [3:0] f);
        logic [15:0] v;
        v = f[0] ? 16'h0040 : 16'h0000;
        applyOp(5'b00100, v, v, 1'b1);
        clockEdge();
        applyOp(5'b10000, f[1] ? 16'h8000 : 16'h0001, 16'h0000, 1'b1);
        clockEdge();
        v = f[3] ? (f[2] ? 16'h0001 : 16'h0000) : (f[2] ? 16'h0003 : 16'h0002);
        applyOp(5'b11101, v, 16'h0000, 1'b1);
        clockEdge();
        checkFlags("preset", f);
    endtask

    initial begin
        totalChecks = 0;
        passChecks  = 0;
        Reset       = 1'b0;
        bus.A       = 16'h0000;
        bus.B       = 16'h0000;
        bus.FunSel  = 5'b00000;
        bus.WF      = 1'b0;
        #2;
        checkFlags("reset_flags", 4'b0000);
        checkVal("reset_out", bus.ALUOut, 16'h0000);
        #10;
        Reset = 1'b1;
        clockEdge();

        // Pass-through 16-bit
        presetFlags(4'b1010);
        applyOp(5'b10000, 16'h1111, 16'h0000, 1'b1);
        checkVal("pass_a16", bus.ALUOut, 16'h1111);
        clockEdge();
        checkFlags("pass_a16_f", 4'b0000);
        presetFlags(4'b0011);
        applyOp(5'b10000, 16'h0000, 16'h0000, 1'b1);
        checkVal("pass_zero", bus.ALUOut, 16'h0000);
        clockEdge();
        checkFlags("pass_zero_f", 4'b1001);

        // NOT 8-bit and NOT B 16-bit
        presetFlags(4'b1100);
        applyOp(5'b00010, 16'hFF11, 16'h0000, 1'b1);
        checkVal("not_a8", bus.ALUOut, 16'h00EE);
        clockEdge();
        checkFlags("not_a8_f", 4'b0110);
        presetFlags(4'b0011);
        applyOp(5'b10011, 16'h0000, 16'h1111, 1'b1);
        checkVal("not_b16", bus.ALUOut, 16'hEEEE);
        clockEdge();
        checkFlags("not_b16_f", 4'b0011);

        // ADD then ADC 8-bit, carry chaining through the register
        presetFlags(4'b1100);
        applyOp(5'b00100, 16'h00AA, 16'h00CC, 1'b1);
        checkVal("add8", bus.ALUOut, 16'h0076);
        clockEdge();
        checkFlags("add8_f", 4'b0111);
        applyOp(5'b00101, 16'h00AA, 16'h0011, 1'b1);
        checkVal("adc8", bus.ALUOut, 16'h00BC);
        clockEdge();
        checkFlags("adc8_f", 4'b0010);

        // SUB: equal operands, and an 8-bit signed overflow
        presetFlags(4'b0000);
        applyOp(5'b10110, 16'h0005, 16'h0005, 1'b1);
        checkVal("sub16", bus.ALUOut, 16'h0000);
        clockEdge();
        checkFlags("sub16_f", 4'b1100);
        applyOp(5'b00110, 16'h0080, 16'h0001, 1'b1);
        checkVal("sub8_ovf", bus.ALUOut, 16'h007F);
        clockEdge();
        checkFlags("sub8_ovf_f", 4'b0111);

        // Logic 16-bit
        applyOp(5'b10111, 16'hF0F0, 16'hFF00, 1'b0);
        checkVal("and16", bus.ALUOut, 16'hF000);
        applyOp(5'b11000, 16'hF0F0, 16'hFF00, 1'b0);
        checkVal("or16", bus.ALUOut, 16'hFFF0);
        applyOp(5'b11001, 16'hF0F0, 16'hFF00, 1'b0);
        checkVal("xor16", bus.ALUOut, 16'h0FF0);
        applyOp(5'b11010, 16'hF0F0, 16'hFF00, 1'b0);
        checkVal("nand16", bus.ALUOut, 16'h0FFF);

        // Shifts
        presetFlags(4'b0011);
        applyOp(5'b11101, 16'h1111, 16'h0000, 1'b1);
        checkVal("asr16", bus.ALUOut, 16'h0888);
        clockEdge();
        checkFlags("asr16_f", 4'b0111);
        presetFlags(4'b1101);
        applyOp(5'b01100, 16'h00AA, 16'h0000, 1'b1);
        checkVal("lsr8", bus.ALUOut, 16'h0055);
        clockEdge();
        checkFlags("lsr8_f", 4'b0001);
        presetFlags(4'b0001);
        applyOp(5'b01011, 16'h0081, 16'h0000, 1'b1);
        checkVal("lsl8", bus.ALUOut, 16'h0002);
        clockEdge();
        checkFlags("lsl8_f", 4'b0101);
        applyOp(5'b11101, 16'h8000, 16'h0000, 1'b0);
        checkVal("asr16_neg", bus.ALUOut, 16'hC000);

        // Rotate through carry
        presetFlags(4'b0100);
        applyOp(5'b11110, 16'h8001, 16'h0000, 1'b1);
`ifdef ALU_ROTATE_EN
        checkVal("csl16", bus.ALUOut, 16'h0003);
        clockEdge();
        checkFlags("csl16_f", 4'b0100);
        applyOp(5'b11111, 16'h8001, 16'h0000, 1'b1);
        checkVal("csr16", bus.ALUOut, 16'hC000);
        clockEdge();
        checkFlags("csr16_f", 4'b0110);
`else
        checkVal("csl16_off", bus.ALUOut, 16'h8001);
        clockEdge();
        checkFlags("csl16_off_f", 4'b0100);
        applyOp(5'b01111, 16'h8001, 16'h0000, 1'b1);
        checkVal("csr8_off", bus.ALUOut, 16'h0001);
        clockEdge();
        checkFlags("csr8_off_f", 4'b0100);
`endif

        // WF=0 holds, then asynchronous reset mid-cycle
        presetFlags(4'b0110);
        applyOp(5'b10000, 16'h0000, 16'h0000, 1'b0);
        clockEdge();
        checkFlags("wf0_hold", 4'b0110);
        #2;
        Reset = 1'b0;
        #1;
        checkFlags("async_reset", 4'b0000);
        Reset = 1'b1;
        clockEdge();
        checkFlags("after_reset", 4'b0000);

        $display("%0d/%0d checks passed", passChecks, totalChecks);
        $finish;
    end

endmodule
